// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
//
// Purpose: bundles the operand/request and result/status signals of the
// sequential divider so they travel together between the issuing stage and
// the divider.
//
// Signals:
//   a, b    [WIDTH]  dividend / divisor, sampled only on an accepted start
//   sign    1        1 = two's-complement operands, 0 = unsigned
//   start   1        request
//   q, r    [WIDTH]  registered quotient / remainder
//   busy    1        operation in progress
//   ready   1        one-cycle pulse: q/r/dz/ovf were just updated
//   dz      1        last result was a divide by zero
//   ovf     1        last result was signed MIN / -1
//
// Handshake: a request is accepted on a rising clock edge where start=1 and
// either busy=0, or the in-flight operation completes on that same edge
// (ready rises on it). a/b/sign are sampled only on that accepting edge.
// A start presented while busy=1 on any other edge is dropped, not queued.
// The result is announced by ready being high for exactly one cycle, and
// q/r/dz/ovf then hold until the next completion.
//
// Modports:
//   master  issuing side (drives operands, observes results)
//   slave   divider side
// -----------------------------------------------------------------------------
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sign;
  logic             start;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             ready;
  logic             dz;
  logic             ovf;

  modport master (
    output a, b, sign, start,
    input  q, r, busy, ready, dz, ovf
  );

  modport slave (
    input  a, b, sign, start,
    output q, r, busy, ready, dz, ovf
  );
endinterface

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
//
// Purpose: radix-2 restoring integer divider for the execute-stage multi-cycle
// unit. Produces one quotient bit per clock on unsigned magnitudes, then
// applies sign correction on the final step. Signed or unsigned mode is
// selected per operation; operands are latched at start so the source
// registers may change while the operation runs.
//
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   asynchronous, active-low reset
//   bus          slave modport of div_seq_if (operands, start, q, r, busy,
//                ready, dz, ovf)
//   dbg_state_o  out  1 while the FSM is in RUN, 0 in IDLE
//
// Timing: start accepted at edge E0; restoring steps at E1..E_WIDTH; results,
// flags and the ready pulse appear after E_WIDTH. busy is high for exactly
// WIDTH cycles regardless of operand values. All outputs come from flops.
// -----------------------------------------------------------------------------
module div_seq #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic      clock,
  input  logic      resetn,
  div_seq_if.slave  bus,
  output logic      dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  // Partial remainder. It is always below the divisor magnitude between
  // steps, so WIDTH bits hold it; the WIDTH+1-bit shifted value used for the
  // trial subtract is formed combinationally below.
  logic [WIDTH-1:0] rem_q,      rem_d;
  // Shift register: dividend magnitude shifts out of the top while quotient
  // bits shift in at the bottom.
  logic [WIDTH-1:0] quo_q,      quo_d;
  logic [WIDTH-1:0] div_q,      div_d;      // divisor magnitude
  logic [WIDTH-1:0] a_orig_q,   a_orig_d;   // raw dividend for the dz result
  logic             qneg_q,     qneg_d;
  logic             rneg_q,     rneg_d;
  logic             dz_pend_q,  dz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;

  // Architectural outputs
  logic [WIDTH-1:0] q_q,        q_d;
  logic [WIDTH-1:0] r_q,        r_d;
  logic             busy_q,     busy_d;
  logic             ready_q,    ready_d;
  logic             dz_q,       dz_d;
  logic             ovf_q,      ovf_d;

  // ---------------------------------------------------------------------------
  // Operand conditioning (used only on an accepting edge)
  // ---------------------------------------------------------------------------
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = bus.sign & bus.a[WIDTH-1];
  assign b_neg = bus.sign & bus.b[WIDTH-1];
  // Negating MIN yields MIN again, which is the correct unsigned magnitude.
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // ---------------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             last_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             accept;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, div_q};
  // trial[WIDTH] set means the subtraction went negative: restore.
  assign q_bit     = ~trial[WIDTH];
  assign rem_step  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], q_bit};
  assign last_step = (state_q == S_RUN) && (cnt_q == LAST_CNT);

  // Sign correction on the final step. A zero divisor overrides the natural
  // result so the remainder is the untouched original dividend in both modes.
  assign q_fix = dz_pend_q ? ONES
               : (qneg_q ? -quo_step : quo_step);
  assign r_fix = dz_pend_q ? a_orig_q
               : (rneg_q ? -rem_step : rem_step);

  // A start is taken when idle, or on the completing edge so back-to-back
  // operations run with no bubble.
  assign accept = bus.start && ((state_q == S_IDLE) || last_step);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    div_d      = div_q;
    a_orig_d   = a_orig_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    q_d        = q_q;
    r_d        = r_q;
    busy_d     = busy_q;
    ready_d    = 1'b0;
    dz_d       = dz_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          q_d     = q_fix;
          r_d     = r_fix;
          dz_d    = dz_pend_q;
          ovf_d   = ovf_pend_q;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
      end
    endcase

    // Loading a new operation overrides the step datapath; the completion
    // above still used the previous operation's latched values.
    if (accept) begin
      quo_d      = a_mag;
      div_d      = b_mag;
      a_orig_d   = bus.a;
      qneg_d     = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      rneg_d     = a_neg;
      dz_pend_d  = (bus.b == '0);
      ovf_pend_d = bus.sign && (bus.a == MIN_VAL) && (bus.b == ONES);
      rem_d      = '0;
      cnt_d      = '0;
      busy_d     = 1'b1;
      state_d    = S_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      a_orig_q   <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      div_q      <= div_d;
      a_orig_q   <= a_orig_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dz_pend_q  <= dz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      q_q        <= q_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.q       = q_q;
  assign bus.r       = r_q;
  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;
  assign bus.dz      = dz_q;
  assign bus.ovf     = ovf_q;
  assign dbg_state_o = (state_q == S_RUN);

endmodule
